pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline boundary register that replaces the per-stage hand-written control registers.
- Carries a valid bit, a register-write control, a destination register index, a generic control bundle and a data word through DEPTH register stages.
- Supports stall, flush and x0 write suppression.
- Used between any two pipeline stages, e.g. Execute→Memory or Memory→WriteBack, and multi-cycle units with DEPTH>1.

Parameters:
DATA_WIDTH, 32, width of data word (ALU result / load data / PC+4)
CTRL_WIDTH, 2, width of generic control bundle (e.g. ResultSrc)
ADDR_WIDTH, 5, width of destination register index
DEPTH, 1, number of register stages, legal range 1..8

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance enable; 0 = stall, all stages hold
flush  input  1  kill all in-flight entries; priority over en
valid_i  input  1  incoming entry is a real instruction
regwrite_i  input  1  incoming register-write request
rd_i  input  ADDR_WIDTH  incoming destination register
ctrl_i  input  CTRL_WIDTH  incoming control bundle
data_i  input  DATA_WIDTH  incoming data word
valid_o  output  1  last-stage valid
regwrite_o  output  1  last-stage qualified register-write
rd_o  output  ADDR_WIDTH  last-stage destination register
ctrl_o  output  CTRL_WIDTH  last-stage control bundle
data_o  output  DATA_WIDTH  last-stage data word

Behaviour:
- Reset:
  - One clock, clk; reset is asynchronous and active-low on rst_n.
  - While rst_n=0, every stage clears valid, regwrite, rd, ctrl and data to 0. All outputs therefore read 0.
  - Release is synchronous to the next clk edge with no extra latency.
- Stage 0 captures the inputs; stage k captures stage k-1; outputs are driven from stage DEPTH-1.
  - Latency is exactly DEPTH enabled edges.
- Priority at each rising edge: rst_n=0 > flush=1 > en=0 > normal advance.
  - flush=1: all stages set valid=0, regwrite=0, rd=0, ctrl=0, data=0. This applies regardless of en and of valid_i. Inputs presented in the same cycle are discarded.
  - en=0, flush=0: all stages hold. Inputs are ignored and not buffered.
  - en=1, flush=0: the whole chain shifts by one stage.
- Write qualification at capture: stored regwrite = regwrite_i & valid_i & (rd_i != 0).
  - An invalid entry or an x0 destination never produces regwrite_o=1.
- An invalid entry (bubble) still propagates ctrl/data/rd as captured, except under flush. Consumers qualify on valid_o.
- Stall and flush never partially shift the chain; there is no per-stage enable.
- Reset asserted mid-stream discards all entries immediately; it does not wait for a clock.
- Parameter check: DEPTH<1 or DEPTH>8, or ADDR_WIDTH<1, raises an elaboration-time error.

Optional Feature:
- Macro: PIPE_STAGE_FWD_EN.
- When defined, the following ports are added:
  - rs1_q, input, ADDR_WIDTH
  - rs2_q, input, ADDR_WIDTH
  - fwd1_hit, output, 1
  - fwd2_hit, output, 1
  - fwd1_data, output, DATA_WIDTH
  - fwd2_data, output, DATA_WIDTH
- Lookup is combinational on current stage contents:
  - hit when a stage has valid=1, regwrite=1 and rd==rs_q, with rs_q != 0.
  - Data comes from the youngest matching stage (lowest index).
  - No hit drives data 0.
- When undefined, these ports and the lookup logic do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset/latency:
  - Stimulus: DEPTH=3, hold rst_n=0, then release; drive valid_i=1, regwrite_i=1, rd_i=5, ctrl_i=2'b01, data_i=32'hDEADBEEF for one cycle with en=1.
  - Required response: all outputs 0 during reset; the entry appears on the outputs exactly 3 edges later with regwrite_o=1; valid_o=0 on the following cycle.
- Stall:
  - Stimulus: DEPTH=2, send entries A (data 1) and B (data 2) on consecutive cycles, then en=0 for 4 cycles.
  - Required response: outputs hold A for all 4 cycles; B appears on the first edge after en returns to 1.
- Flush priority:
  - Stimulus: DEPTH=2, two valid entries in flight; assert flush=1 together with en=0 and valid_i=1, rd_i=7.
  - Required response: on the next edge all stages are cleared, valid_o=0 and regwrite_o=0 for 2 cycles; the rd=7 entry never appears.
- Write qualification:
  - Stimulus 1: regwrite_i=1, rd_i=0, valid_i=1. Required response: regwrite_o=0, valid_o=1.
  - Stimulus 2: regwrite_i=1, rd_i=3, valid_i=0. Required response: regwrite_o=0, valid_o=0.
- Async reset mid-stream:
  - Stimulus: DEPTH=4, pipeline full; drop rst_n between clock edges.
  - Required response: all outputs go to 0 before the next clk edge.
- Forwarding (PIPE_STAGE_FWD_EN defined, DEPTH=3):
  - Stimulus: stage0 holds rd=4, data=0x11 and stage2 holds rd=4, data=0x22, both valid with regwrite=1; rs1_q=4, rs2_q=0.
  - Required response: fwd1_hit=1, fwd1_data=0x11; fwd2_hit=0, fwd2_data=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline boundary register.
// Carries valid, qualified regwrite, rd, a control bundle and a data word
// through DEPTH register stages with whole-chain stall and flush.
// Optional build macro PIPE_STAGE_FWD_EN adds a combinational forwarding
// lookup (rs1_q/rs2_q -> fwd*_hit/fwd*_data) over the in-flight stages.
module pipe_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  valid_i,
  input  logic                  regwrite_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0] data_i,
`ifdef PIPE_STAGE_FWD_EN
  input  logic [ADDR_WIDTH-1:0] rs1_q,
  input  logic [ADDR_WIDTH-1:0] rs2_q,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic [DATA_WIDTH-1:0] fwd2_data,
`endif
  output logic                  valid_o,
  output logic                  regwrite_o,
  output logic [ADDR_WIDTH-1:0] rd_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Reject illegal configurations while elaborating.
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be in 1..8");
  end
  if (ADDR_WIDTH < 1) begin : g_bad_addr
    $error("pipe_stage_reg: ADDR_WIDTH must be at least 1");
  end

  // Stage storage; index 0 is the youngest entry, DEPTH-1 drives the outputs.
  logic                  valid_q    [DEPTH];
  logic                  regwrite_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_q       [DEPTH];
  logic [CTRL_WIDTH-1:0] ctrl_q     [DEPTH];
  logic [DATA_WIDTH-1:0] data_q     [DEPTH];

  logic                  valid_d    [DEPTH];
  logic                  regwrite_d [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_d       [DEPTH];
  logic [CTRL_WIDTH-1:0] ctrl_d     [DEPTH];
  logic [DATA_WIDTH-1:0] data_d     [DEPTH];

  // A write only survives capture if the entry is real and targets a non-x0 register.
  logic cap_regwrite;
  assign cap_regwrite = regwrite_i & valid_i & (rd_i != '0);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic                  src_valid;
    logic                  src_regwrite;
    logic [ADDR_WIDTH-1:0] src_rd;
    logic [CTRL_WIDTH-1:0] src_ctrl;
    logic [DATA_WIDTH-1:0] src_data;

    if (gi == 0) begin : g_head
      assign src_valid    = valid_i;
      assign src_regwrite = cap_regwrite;
      assign src_rd       = rd_i;
      assign src_ctrl     = ctrl_i;
      assign src_data     = data_i;
    end else begin : g_body
      assign src_valid    = valid_q[gi-1];
      assign src_regwrite = regwrite_q[gi-1];
      assign src_rd       = rd_q[gi-1];
      assign src_ctrl     = ctrl_q[gi-1];
      assign src_data     = data_q[gi-1];
    end

    // Next state: flush clears, stall holds, otherwise take the upstream entry.
    always_comb begin
      valid_d[gi]    = valid_q[gi];
      regwrite_d[gi] = regwrite_q[gi];
      rd_d[gi]       = rd_q[gi];
      ctrl_d[gi]     = ctrl_q[gi];
      data_d[gi]     = data_q[gi];
      if (flush) begin
        valid_d[gi]    = 1'b0;
        regwrite_d[gi] = 1'b0;
        rd_d[gi]       = '0;
        ctrl_d[gi]     = '0;
        data_d[gi]     = '0;
      end else if (en) begin
        valid_d[gi]    = src_valid;
        regwrite_d[gi] = src_regwrite;
        rd_d[gi]       = src_rd;
        ctrl_d[gi]     = src_ctrl;
        data_d[gi]     = src_data;
      end
    end

    // Stage register; reset empties the stage immediately, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[gi]    <= 1'b0;
        regwrite_q[gi] <= 1'b0;
        rd_q[gi]       <= '0;
        ctrl_q[gi]     <= '0;
        data_q[gi]     <= '0;
      end else begin
        valid_q[gi]    <= valid_d[gi];
        regwrite_q[gi] <= regwrite_d[gi];
        rd_q[gi]       <= rd_d[gi];
        ctrl_q[gi]     <= ctrl_d[gi];
        data_q[gi]     <= data_d[gi];
      end
    end
  end

  assign valid_o    = valid_q[DEPTH-1];
  assign regwrite_o = regwrite_q[DEPTH-1];
  assign rd_o       = rd_q[DEPTH-1];
  assign ctrl_o     = ctrl_q[DEPTH-1];
  assign data_o     = data_q[DEPTH-1];

`ifdef PIPE_STAGE_FWD_EN
  // Forwarding lookup: scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && regwrite_q[k] && (rs1_q != '0) && (rd_q[k] == rs1_q)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = data_q[k];
      end
      if (valid_q[k] && regwrite_q[k] && (rs2_q != '0) && (rd_q[k] == rs2_q)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = data_q[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: three instances (DEPTH 2, 3, 4) share one
// input bus; a queue-based reference model checks every cycle, with a
// directed vector table and hand-written stall/flush/reset/forward sequences.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  ctrl;
    logic [31:0] data;
  } entry_t;

  typedef struct packed {
    logic        en;
    logic        flush;
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  ctrl;
    logic [31:0] data;
    entry_t      exp3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, en, flush, valid_i, regwrite_i;
  logic [4:0]  rd_i, rs1_q, rs2_q;
  logic [1:0]  ctrl_i;
  logic [31:0] data_i;

  logic        v2, rw2, v3, rw3, v4, rw4;
  logic [4:0]  rd2, rd3, rd4;
  logic [1:0]  c2, c3, c4;
  logic [31:0] d2, d3, d4;
  logic        f1h2, f2h2, f1h3, f2h3, f1h4, f2h4;
  logic [31:0] f1d2, f2d2, f1d3, f2d3, f1d4, f2d4;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_i(valid_i),
    .regwrite_i(regwrite_i), .rd_i(rd_i), .ctrl_i(ctrl_i), .data_i(data_i),
`ifdef PIPE_STAGE_FWD_EN
    .rs1_q(rs1_q), .rs2_q(rs2_q), .fwd1_hit(f1h2), .fwd2_hit(f2h2),
    .fwd1_data(f1d2), .fwd2_data(f2d2),
`endif
    .valid_o(v2), .regwrite_o(rw2), .rd_o(rd2), .ctrl_o(c2), .data_o(d2));

  pipe_stage_reg #(.DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_i(valid_i),
    .regwrite_i(regwrite_i), .rd_i(rd_i), .ctrl_i(ctrl_i), .data_i(data_i),
`ifdef PIPE_STAGE_FWD_EN
    .rs1_q(rs1_q), .rs2_q(rs2_q), .fwd1_hit(f1h3), .fwd2_hit(f2h3),
    .fwd1_data(f1d3), .fwd2_data(f2d3),
`endif
    .valid_o(v3), .regwrite_o(rw3), .rd_o(rd3), .ctrl_o(c3), .data_o(d3));

  pipe_stage_reg #(.DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_i(valid_i),
    .regwrite_i(regwrite_i), .rd_i(rd_i), .ctrl_i(ctrl_i), .data_i(data_i),
`ifdef PIPE_STAGE_FWD_EN
    .rs1_q(rs1_q), .rs2_q(rs2_q), .fwd1_hit(f1h4), .fwd2_hit(f2h4),
    .fwd1_data(f1d4), .fwd2_data(f2d4),
`endif
    .valid_o(v4), .regwrite_o(rw4), .rd_o(rd4), .ctrl_o(c4), .data_o(d4));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one queue per instance, index 0 = newest captured entry.
  entry_t m2[$];
  entry_t m3[$];
  entry_t m4[$];

  function automatic entry_t ent(input logic v, input logic rw, input logic [4:0] rd,
                                 input logic [1:0] c, input logic [31:0] d);
    entry_t e;
    e.v = v; e.rw = rw; e.rd = rd; e.ctrl = c; e.data = d;
    return e;
  endfunction

  function automatic vec_t mk(input logic e, input logic f, input logic v, input logic rw,
                              input logic [4:0] rd, input logic [1:0] c,
                              input logic [31:0] d, input entry_t x);
    vec_t t;
    t.en = e; t.flush = f; t.v = v; t.rw = rw; t.rd = rd; t.ctrl = c; t.data = d;
    t.exp3 = x;
    return t;
  endfunction

  function automatic entry_t captured();
    return ent(valid_i, regwrite_i && valid_i && (rd_i != 5'd0), rd_i, ctrl_i, data_i);
  endfunction

  task automatic clear_models();
    m2.delete(); m3.delete(); m4.delete();
    for (int i = 0; i < 2; i++) m2.push_back('0);
    for (int i = 0; i < 3; i++) m3.push_back('0);
    for (int i = 0; i < 4; i++) m4.push_back('0);
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    entry_t e;
    if (!rst_n || flush) begin
      clear_models();
    end else if (en) begin
      e = captured();
      m2.push_front(e); void'(m2.pop_back());
      m3.push_front(e); void'(m3.pop_back());
      m4.push_front(e); void'(m4.pop_back());
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_all();
    check("u2 vs model", 64'({v2, rw2, rd2, c2, d2}), 64'(m2[$]));
    check("u3 vs model", 64'({v3, rw3, rd3, c3, d3}), 64'(m3[$]));
    check("u4 vs model", 64'({v4, rw4, rd4, c4, d4}), 64'(m4[$]));
`ifdef PIPE_STAGE_FWD_EN
    begin
      logic h1, h2;
      logic [31:0] x1, x2;
      h1 = 1'b0; h2 = 1'b0; x1 = '0; x2 = '0;
      // first match from the youngest end wins
      for (int k = 0; k < 3; k++) begin
        if (!h1 && m3[k].v && m3[k].rw && rs1_q != 0 && m3[k].rd == rs1_q) begin
          h1 = 1'b1; x1 = m3[k].data;
        end
        if (!h2 && m3[k].v && m3[k].rw && rs2_q != 0 && m3[k].rd == rs2_q) begin
          h2 = 1'b1; x2 = m3[k].data;
        end
      end
      check("u3 fwd1 vs model", 64'({f1h3, f1d3}), 64'({h1, x1}));
      check("u3 fwd2 vs model", 64'({f2h3, f2d3}), 64'({h2, x2}));
    end
`endif
  endtask

  task automatic drive(input logic e, input logic f, input logic v, input logic rw,
                       input logic [4:0] rd, input logic [1:0] c, input logic [31:0] d);
    en = e; flush = f; valid_i = v; regwrite_i = rw; rd_i = rd; ctrl_i = c; data_i = d;
  endtask

  // One clock: inputs already driven, wait past the edge, compare against the model.
  task automatic tick();
    @(negedge clk);
    cmp_all();
  endtask

  vec_t tbl[9];

  initial begin
    // directed latency / qualification vectors, checked on the DEPTH=3 instance
    tbl[0] = mk(1, 0, 1, 1, 5'd5, 2'd1, 32'hDEADBEEF, '0);
    tbl[1] = mk(1, 0, 0, 0, 5'd0, 2'd0, 32'h0, '0);
    tbl[2] = mk(1, 0, 0, 0, 5'd0, 2'd0, 32'h0, ent(1, 1, 5'd5, 2'd1, 32'hDEADBEEF));
    tbl[3] = mk(1, 0, 0, 0, 5'd0, 2'd0, 32'h0, '0);
    tbl[4] = mk(1, 0, 1, 1, 5'd0, 2'd2, 32'hA5, '0);
    tbl[5] = mk(1, 0, 0, 1, 5'd3, 2'd3, 32'h77, '0);
    tbl[6] = mk(1, 0, 0, 0, 5'd0, 2'd0, 32'h0, ent(1, 0, 5'd0, 2'd2, 32'hA5));
    tbl[7] = mk(1, 0, 0, 0, 5'd0, 2'd0, 32'h0, ent(0, 0, 5'd3, 2'd3, 32'h77));
    tbl[8] = mk(1, 0, 0, 0, 5'd0, 2'd0, 32'h0, '0);

    rs1_q = '0; rs2_q = '0;
    rst_n = 1'b0;
    drive(1, 0, 1, 1, 5'd5, 2'd1, 32'hFFFF);
    clear_models();

    // outputs read zero while reset is held, even with live inputs
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset u3 outputs", 64'({v3, rw3, rd3, c3, d3}), 64'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].en, tbl[i].flush, tbl[i].v, tbl[i].rw, tbl[i].rd, tbl[i].ctrl, tbl[i].data);
      tick();
      check($sformatf("table[%0d]", i), 64'({v3, rw3, rd3, c3, d3}), 64'(tbl[i].exp3));
    end

    // stall on DEPTH=2: A then B, four stalled cycles with junk on the inputs
    drive(1, 0, 1, 1, 5'd1, 2'd0, 32'd1); tick();
    drive(1, 0, 1, 1, 5'd2, 2'd0, 32'd2); tick();
    check("stall A visible", 64'({v2, d2}), 64'({1'b1, 32'd1}));
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 5'd9, 2'd3, 32'd99); tick();
      check($sformatf("stall hold %0d", i), 64'({v2, rd2, d2}), 64'({1'b1, 5'd1, 32'd1}));
    end
    drive(1, 0, 1, 1, 5'd6, 2'd1, 32'd3); tick();
    check("stall B after resume", 64'({v2, rd2, d2}), 64'({1'b1, 5'd2, 32'd2}));

    // flush with en=0 and a valid rd=7 entry on the inputs
    drive(0, 1, 1, 1, 5'd7, 2'd0, 32'd7); tick();
    check("flush edge", 64'({v2, rw2, rd2, d2}), 64'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 5'd0, 2'd0, 32'd0); tick();
      check($sformatf("post flush %0d", i), 64'({v2, rw2, rd2, d2}), 64'd0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 7)), 2'($urandom), $urandom);
      rs1_q = 5'($urandom_range(0, 7));
      rs2_q = 5'($urandom_range(0, 7));
      tick();
    end
    rs1_q = '0; rs2_q = '0;

    // asynchronous reset with a full DEPTH=4 pipeline
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 1, 5'(i + 1), 2'd1, 32'h100 + i); tick();
    end
    check("u4 full before reset", 64'({v4, rd4, d4}), 64'({1'b1, 5'd1, 32'h100}));
    #2 rst_n = 1'b0;
    #1;
    check("async reset u4", 64'({v4, rw4, rd4, c4, d4}), 64'd0);
    check("async reset u2", 64'({v2, rw2, rd2, c2, d2}), 64'd0);
    drive(0, 0, 0, 0, 5'd0, 2'd0, 32'd0);
    tick();
    rst_n = 1'b1;

`ifdef PIPE_STAGE_FWD_EN
    // stage2: rd4/0x22, stage1: rd9/0x33, stage0: rd4/0x11
    drive(1, 0, 1, 1, 5'd4, 2'd0, 32'h22); tick();
    drive(1, 0, 1, 1, 5'd9, 2'd0, 32'h33); tick();
    drive(1, 0, 1, 1, 5'd4, 2'd0, 32'h11); tick();
    drive(0, 0, 0, 0, 5'd0, 2'd0, 32'd0);
    rs1_q = 5'd4; rs2_q = 5'd0;
    #1;
    check("fwd1 youngest", 64'({f1h3, f1d3}), 64'({1'b1, 32'h11}));
    check("fwd2 x0 no hit", 64'({f2h3, f2d3}), 64'd0);
    rs2_q = 5'd9;
    #1;
    check("fwd2 middle", 64'({f2h3, f2d3}), 64'({1'b1, 32'h33}));
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
